// File: rtl/cb_stripe_feeder.sv
// Code-block buffer and stripe-scan sequencer: stores one raster-order block in four
// row banks, then replays it per bit plane (top plane down to 0) in JPEG2000 stripe order.
module cb_stripe_feeder #(
   parameter int CB_W   = 8,
   parameter int CB_H   = 8,
   parameter int W_COEF = 16,
   parameter int W_BP   = $clog2(W_COEF-1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_COEF-1:0] in_coeff,
   input  logic              out_ready,
   output logic              coef_en,
   output logic [W_COEF-1:0] coeff0,
   output logic [W_COEF-1:0] coeff1,
   output logic [W_COEF-1:0] coeff2,
   output logic [W_COEF-1:0] coeff3,
   output logic [3:0]        row_mask,
   output logic              first_row,
   output logic              first_col,
   output logic              last_col,
   output logic              first_plane,
   output logic [W_BP-1:0]   bit_pos,
   output logic              plane_end,
   output logic              cb_done,
   output logic              cb_empty
);

   localparam int NS    = (CB_H + 3) / 4;
   localparam int DEPTH = NS * CB_W;
   localparam int W_A   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int W_R   = $clog2(CB_H + 1);
   localparam int W_C   = $clog2(CB_W);
   localparam int W_S   = (NS > 1) ? $clog2(NS) : 1;
   localparam int W_M   = W_COEF - 1;

   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

   function automatic logic [W_BP-1:0] f_msb(input logic [W_M-1:0] v);
      f_msb = '0;
      for (int i = 0; i < W_M; i++)
         if (v[i]) f_msb = W_BP'(i);
   endfunction

   state_t r_state;
   state_t w_state_nx;

   logic                     r_in_rdy;
   logic [W_R-1:0]           r_wrow;
   logic [W_C-1:0]           r_wcol;
   logic [W_M-1:0]           r_acc;
   logic [W_BP-1:0]          r_top;
   logic                     r_empty;
   logic                     r_done;
   logic [W_COEF-1:0]        r_mem [4][DEPTH];

   logic [W_S-1:0]           r_rs;
   logic [W_C-1:0]           r_rc;
   logic [W_BP-1:0]          r_rbp;
   logic                     r_rmore;

   logic                     r_vld;
   logic [3:0][W_COEF-1:0]   r_coef;
   logic [3:0]               r_mask;
   logic                     r_frow;
   logic                     r_fcol;
   logic                     r_lcol;
   logic                     r_fplane;
   logic [W_BP-1:0]          r_bp;
   logic                     r_pend;

   logic                     w_in_acc;
   logic                     w_wlast;
   logic [W_M-1:0]           w_acc_nx;
   logic [W_A-1:0]           w_waddr;
   logic [1:0]               w_wbank;
   logic                     w_scan_go;
   logic [W_A-1:0]           w_raddr;
   logic                     w_free;
   logic                     w_issue;
   logic                     w_rlast_col;
   logic                     w_rlast_s;
   logic                     w_xfer_last;
   logic [3:0]               w_row_ok;

   assign w_in_acc    = in_valid & r_in_rdy;
   assign w_wlast     = (r_wrow == W_R'(CB_H - 1)) && (r_wcol == W_C'(CB_W - 1));
   assign w_acc_nx    = ((r_state == IDLE) ? '0 : r_acc) | in_coeff[W_M-1:0];
   assign w_waddr     = W_A'(32'(r_wrow >> 2) * CB_W + 32'(r_wcol));
   assign w_wbank     = 2'(r_wrow);
   assign w_scan_go   = w_in_acc & w_wlast & (w_acc_nx != '0);

   assign w_raddr     = W_A'(32'(r_rs) * CB_W + 32'(r_rc));
   assign w_free      = ~r_vld | out_ready;
   assign w_issue     = (r_state == SCAN) & r_rmore & w_free;
   assign w_rlast_col = (r_rc == W_C'(CB_W - 1));
   assign w_rlast_s   = (r_rs == W_S'(NS - 1));
   assign w_xfer_last = r_vld & out_ready & r_pend & (r_bp == '0);

   always_comb begin
      w_row_ok = '0;
      for (int k = 0; k < 4; k++)
         w_row_ok[k] = (32'(r_rs) * 4 + k) < CB_H;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE, LOAD: begin
            if (w_in_acc) begin
               if (!w_wlast)              w_state_nx = LOAD;
               else if (w_acc_nx == '0)   w_state_nx = IDLE;
               else                       w_state_nx = SCAN;
            end
         end
         SCAN:    if (w_xfer_last) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Load side: raster counters, magnitude OR accumulator, top-plane capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_rdy <= 1'b0;
         r_wrow   <= '0;
         r_wcol   <= '0;
         r_acc    <= '0;
         r_top    <= '0;
         r_empty  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_in_rdy <= (w_state_nx != SCAN);
         r_empty  <= w_in_acc & w_wlast & (w_acc_nx == '0);
         r_done   <= w_xfer_last;
         if (w_in_acc) begin
            r_acc <= w_acc_nx;
            if (w_wlast) begin
               r_wrow <= '0;
               r_wcol <= '0;
               r_top  <= f_msb(w_acc_nx);
            end else if (r_wcol == W_C'(CB_W - 1)) begin
               r_wcol <= '0;
               r_wrow <= r_wrow + W_R'(1);
            end else begin
               r_wcol <= r_wcol + W_C'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_acc) r_mem[w_wbank][w_waddr] <= in_coeff;
   end

   // Scan side: the memory read register doubles as the output register, so a
   // read is issued only when that register is empty or its beat is leaving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rs     <= '0;
         r_rc     <= '0;
         r_rbp    <= '0;
         r_rmore  <= 1'b0;
         r_vld    <= 1'b0;
         r_coef   <= '0;
         r_mask   <= '0;
         r_frow   <= 1'b0;
         r_fcol   <= 1'b0;
         r_lcol   <= 1'b0;
         r_fplane <= 1'b0;
         r_bp     <= '0;
         r_pend   <= 1'b0;
      end else begin
         if (w_scan_go) begin
            r_rs    <= '0;
            r_rc    <= '0;
            r_rbp   <= f_msb(w_acc_nx);
            r_rmore <= 1'b1;
         end else if (w_issue) begin
            if (w_rlast_col) begin
               r_rc <= '0;
               if (w_rlast_s) begin
                  r_rs <= '0;
                  if (r_rbp == '0) r_rmore <= 1'b0;
                  else             r_rbp   <= r_rbp - W_BP'(1);
               end else begin
                  r_rs <= r_rs + W_S'(1);
               end
            end else begin
               r_rc <= r_rc + W_C'(1);
            end
         end

         if (w_issue) begin
            r_vld <= 1'b1;
            for (int k = 0; k < 4; k++)
               r_coef[k] <= w_row_ok[k] ? r_mem[k][w_raddr] : '0;
            r_mask   <= w_row_ok;
            r_frow   <= (r_rs == '0);
            r_fcol   <= (r_rc == '0);
            r_lcol   <= w_rlast_col;
            r_fplane <= (r_rbp == r_top);
            r_bp     <= r_rbp;
            r_pend   <= w_rlast_s & w_rlast_col;
         end else if (w_free) begin
            r_vld    <= 1'b0;
            r_coef   <= '0;
            r_mask   <= '0;
            r_frow   <= 1'b0;
            r_fcol   <= 1'b0;
            r_lcol   <= 1'b0;
            r_fplane <= 1'b0;
            r_bp     <= '0;
            r_pend   <= 1'b0;
         end
      end
   end

   assign in_ready    = r_in_rdy;
   assign coef_en     = r_vld;
   assign coeff0      = r_coef[0];
   assign coeff1      = r_coef[1];
   assign coeff2      = r_coef[2];
   assign coeff3      = r_coef[3];
   assign row_mask    = r_mask;
   assign first_row   = r_frow;
   assign first_col   = r_fcol;
   assign last_col    = r_lcol;
   assign first_plane = r_fplane;
   assign bit_pos     = r_bp;
   assign plane_end   = r_pend;
   assign cb_done     = r_done;
   assign cb_empty    = r_empty;

endmodule

// File: tb/tb_cb_stripe_feeder.sv
// Scoreboard bench for cb_stripe_feeder: an 8x8 instance and a 4x6 partial-stripe instance.
`timescale 1ns/1ps
module tb_cb_stripe_feeder;

   typedef logic [76:0] beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a, iv_a, ir_a, ce_a, fr_a, fc_a, lc_a, fp_a, pe_a, dn_a, em_a;
   logic        or_a = 1'b1;
   logic [15:0] ic_a, c0_a, c1_a, c2_a, c3_a;
   logic [3:0]  rm_a, bp_a;
   logic        rst_b, iv_b, ir_b, or_b, ce_b, fr_b, fc_b, lc_b, fp_b, pe_b, dn_b, em_b;
   logic [15:0] ic_b, c0_b, c1_b, c2_b, c3_b;
   logic [3:0]  rm_b, bp_b;

   cb_stripe_feeder #(.CB_W(8), .CB_H(8), .W_COEF(16)) u_a (
      .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_coeff(ic_a),
      .out_ready(or_a), .coef_en(ce_a), .coeff0(c0_a), .coeff1(c1_a), .coeff2(c2_a),
      .coeff3(c3_a), .row_mask(rm_a), .first_row(fr_a), .first_col(fc_a),
      .last_col(lc_a), .first_plane(fp_a), .bit_pos(bp_a), .plane_end(pe_a),
      .cb_done(dn_a), .cb_empty(em_a));

   cb_stripe_feeder #(.CB_W(4), .CB_H(6), .W_COEF(16)) u_b (
      .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(ir_b), .in_coeff(ic_b),
      .out_ready(or_b), .coef_en(ce_b), .coeff0(c0_b), .coeff1(c1_b), .coeff2(c2_b),
      .coeff3(c3_b), .row_mask(rm_b), .first_row(fr_b), .first_col(fc_b),
      .last_col(lc_b), .first_plane(fp_b), .bit_pos(bp_b), .plane_end(pe_b),
      .cb_done(dn_b), .cb_empty(em_b));

   int          n_tests = 0;
   int          n_fail  = 0;
   beat_t       qa[$];
   beat_t       qb[$];
   logic [15:0] blk [64];
   int          popc_a[$];
   logic [3:0]  popbp_a[$];
   logic [3:0]  poprm_b[$];
   logic [3:0]  popfr_b[$];
   int          n_done_a = 0;
   int          n_done_b = 0;
   bit          bp_mode  = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input beat_t act, input beat_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic beat_t pk(input logic [15:0] a0, a1, a2, a3, input logic [3:0] m,
                                input logic fr, fc, lc, fp, input logic [3:0] bp,
                                input logic pe);
      return {a3, a2, a1, a0, m, fr, fc, lc, fp, bp, pe};
   endfunction

   // Directed block contents: 0 = 8x8 max 0x7F, 1 = 8x8 max 5, 2 = 4x6 max 1, 3 = all zero.
   function automatic logic [15:0] gen(input int kind, input int i);
      int mag;
      bit sg;
      case (kind)
         0:       begin sg = (i % 3 == 0); mag = (i == 27) ? 127 : (i * 37) % 127; end
         1:       begin sg = (i % 2 == 1); mag = (i * 5) % 6; end
         2:       begin sg = (i % 4 == 3); mag = (i % 3 == 0) ? 1 : 0; end
         default: begin sg = 1'b1; mag = 0; end
      endcase
      return {sg, 15'(mag)};
   endfunction

   task automatic model(input int w, input int h, input bit to_b);
      logic [14:0] acc;
      logic [15:0] c [4];
      logic [3:0]  m;
      int          top, ns, r;
      beat_t       bt;
      acc = '0;
      for (int i = 0; i < w * h; i++) acc |= blk[i][14:0];
      top = -1;
      for (int i = 0; i < 15; i++) if (acc[i]) top = i;
      ns = (h + 3) / 4;
      for (int p = top; p >= 0; p--)
         for (int s = 0; s < ns; s++)
            for (int col = 0; col < w; col++) begin
               for (int k = 0; k < 4; k++) begin
                  r = 4 * s + k;
                  c[k] = (r < h) ? blk[r * w + col] : 16'h0;
                  m[k] = (r < h);
               end
               bt = pk(c[0], c[1], c[2], c[3], m, s == 0, col == 0, col == w - 1,
                       p == top, 4'(p), (s == ns - 1) && (col == w - 1));
               if (to_b) qb.push_back(bt);
               else      qa.push_back(bt);
            end
   endtask

   task automatic send_a(input logic [15:0] v, input bit gap, output int t_acc);
      bit acc;
      int g;
      if (gap) begin
         iv_a = 1'b0;
         @(posedge clk); #1;
      end
      iv_a = 1'b1; ic_a = v; acc = 1'b0; g = 0; t_acc = -1;
      while (!acc && g < 3000) begin
         @(negedge clk);
         acc = ir_a; t_acc = cyc;
         @(posedge clk); #1;
         g++;
      end
      iv_a = 1'b0;
      if (!acc) chk("send_a_timeout", ir_a, 1);
   endtask

   task automatic send_b(input logic [15:0] v);
      bit acc;
      int g;
      iv_b = 1'b1; ic_b = v; acc = 1'b0; g = 0;
      while (!acc && g < 3000) begin
         @(negedge clk);
         acc = ir_b;
         @(posedge clk); #1;
         g++;
      end
      iv_b = 1'b0;
      if (!acc) chk("send_b_timeout", ir_b, 1);
   endtask

   task automatic wait_done_a(input int target);
      int g = 0;
      while (n_done_a < target && g < 5000) begin @(posedge clk); g++; end
      chk("done_count_a", n_done_a, target);
      @(posedge clk); #1;
      chk("queue_drained_a", qa.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      or_a = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   beat_t hold_a;
   bit    stall_a = 1'b0;
   bit    due_a   = 1'b0;
   always @(negedge clk) begin
      beat_t cur, e;
      if (rst_a) begin
         stall_a = 1'b0;
         due_a   = 1'b0;
      end else begin
         if (due_a) begin
            chk("cb_done_pulse_a", dn_a, 1);
            due_a = 1'b0;
         end else if (dn_a) begin
            chk("cb_done_spurious_a", dn_a, 0);
         end
         if (dn_a) n_done_a++;
         cur = pk(c0_a, c1_a, c2_a, c3_a, rm_a, fr_a, fc_a, lc_a, fp_a, bp_a, pe_a);
         if (ce_a) begin
            if (stall_a) chkb("stall_hold_a", cur, hold_a);
            chk("in_ready_in_scan_a", ir_a, 0);
            if (or_a) begin
               stall_a = 1'b0;
               if (qa.size() == 0) chk("beat_without_expect_a", ce_a, 0);
               else begin
                  e = qa.pop_front();
                  chkb("beat_a", cur, e);
                  popc_a.push_back(cyc);
                  popbp_a.push_back(bp_a);
                  if (e[0] && e[4:1] == 4'd0) due_a = 1'b1;
               end
            end else begin
               stall_a = 1'b1;
               hold_a  = cur;
            end
         end else if (stall_a) begin
            chk("coef_en_dropped_a", ce_a, 1);
            stall_a = 1'b0;
         end
      end
   end

   bit due_b = 1'b0;
   always @(negedge clk) begin
      beat_t cur, e;
      if (rst_b) due_b = 1'b0;
      else begin
         if (due_b) begin
            chk("cb_done_pulse_b", dn_b, 1);
            due_b = 1'b0;
         end else if (dn_b) begin
            chk("cb_done_spurious_b", dn_b, 0);
         end
         if (dn_b) n_done_b++;
         if (ce_b) begin
            cur = pk(c0_b, c1_b, c2_b, c3_b, rm_b, fr_b, fc_b, lc_b, fp_b, bp_b, pe_b);
            if (qb.size() == 0) chk("beat_without_expect_b", ce_b, 0);
            else begin
               e = qb.pop_front();
               chkb("beat_b", cur, e);
               poprm_b.push_back(rm_b);
               popfr_b.push_back({3'b0, fr_b});
               if (e[0] && e[4:1] == 4'd0) due_b = 1'b1;
            end
         end
      end
   end

   initial begin
      int t, base, d0, g;
      rst_a = 1'b1; rst_b = 1'b1; iv_a = 1'b0; iv_b = 1'b0;
      ic_a = '0; ic_b = '0; or_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", ir_a, 0);
      chk("rst_coef_en", ce_a, 0);
      chk("rst_cb_done", dn_a, 0);
      chk("rst_cb_empty", em_a, 0);
      chk("rst_bit_pos", bp_a, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", ir_a, 1);

      // Full 8x8 block, no backpressure.
      for (int i = 0; i < 64; i++) blk[i] = gen(0, i);
      model(8, 8, 0);
      base = popc_a.size();
      for (int i = 0; i < 64; i++) send_a(blk[i], 1'b0, t);
      wait_done_a(1);
      chk("beats_full", popc_a.size() - base, 112);
      chk("first_beat_latency", popc_a[base] - t, 2);
      chk("zero_bubbles", popc_a[base + 111] - popc_a[base], 111);
      chk("top_plane", popbp_a[base], 6);
      chk("last_plane", popbp_a[base + 111], 0);

      // Same block under random backpressure.
      bp_mode = 1'b1;
      model(8, 8, 0);
      base = popc_a.size();
      for (int i = 0; i < 64; i++) send_a(blk[i], 1'b0, t);
      wait_done_a(2);
      chk("beats_backpressure", popc_a.size() - base, 112);
      bp_mode = 1'b0;
      @(posedge clk); #1;

      // All-zero magnitudes with sign bits set.
      for (int i = 0; i < 64; i++) blk[i] = gen(3, i);
      for (int i = 0; i < 64; i++) send_a(blk[i], 1'b0, t);
      @(negedge clk);
      chk("cb_empty_pulse", em_a, 1);
      @(negedge clk);
      chk("cb_empty_one_cycle", em_a, 0);
      chk("in_ready_after_empty", ir_a, 1);
      @(posedge clk); #1;

      // Input gaps, then a second block offered while the first is scanning.
      for (int i = 0; i < 64; i++) blk[i] = gen(0, i);
      model(8, 8, 0);
      for (int i = 0; i < 64; i++) send_a(blk[i], (i % 2 == 1), t);
      d0 = n_done_a;
      for (int i = 0; i < 64; i++) blk[i] = gen(1, i);
      model(8, 8, 0);
      base = popc_a.size();
      send_a(blk[0], 1'b0, t);
      chk("second_block_after_done", n_done_a, d0 + 1);
      for (int i = 1; i < 64; i++) send_a(blk[i], 1'b0, t);
      wait_done_a(d0 + 2);
      chk("beats_both_blocks", popc_a.size() - base, 112 + 48);

      // Reset while plane 3, beat 5 is on the output.
      for (int i = 0; i < 64; i++) blk[i] = gen(0, i);
      model(8, 8, 0);
      base = popc_a.size();
      for (int i = 0; i < 64; i++) send_a(blk[i], 1'b0, t);
      g = 0;
      while (popc_a.size() < base + 53 && g < 2000) begin @(posedge clk); g++; end
      #3;
      chk("pre_reset_bit_pos", bp_a, 3);
      chk("pre_reset_coef_en", ce_a, 1);
      rst_a = 1'b1;
      #1;
      chk("rst_async_coef_en", ce_a, 0);
      chk("rst_async_bit_pos", bp_a, 0);
      chk("rst_async_coeff0", c0_a, 0);
      chk("rst_async_in_ready", ir_a, 0);
      qa.delete();
      d0 = n_done_a;
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_abort", ir_a, 1);
      chk("no_done_after_abort", n_done_a, d0);
      for (int i = 0; i < 64; i++) blk[i] = gen(1, i);
      model(8, 8, 0);
      base = popc_a.size();
      for (int i = 0; i < 64; i++) send_a(blk[i], 1'b0, t);
      wait_done_a(d0 + 1);
      chk("beats_after_abort", popc_a.size() - base, 48);
      chk("top_after_abort", popbp_a[base], 2);

      // Partial last stripe on the 4x6 instance.
      for (int i = 0; i < 24; i++) blk[i] = gen(2, i);
      model(4, 6, 1);
      for (int i = 0; i < 24; i++) send_b(blk[i]);
      g = 0;
      while (n_done_b < 1 && g < 500) begin @(posedge clk); g++; end
      chk("done_count_b", n_done_b, 1);
      chk("beats_partial", poprm_b.size(), 8);
      if (poprm_b.size() == 8) begin
         chk("mask_stripe0", poprm_b[0], 4'b1111);
         chk("mask_stripe1", poprm_b[4], 4'b0011);
         chk("first_row_beat3", popfr_b[3], 1);
         chk("first_row_beat4", popfr_b[4], 0);
      end

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cb_stripe_feeder.md
# cb_stripe_feeder

Code-block buffer and stripe-scan sequencer placed in front of `bpc`. It accepts one code-block of sign-magnitude wavelet coefficients in raster order and stores it in four row-banked memories. It finds the most significant non-zero magnitude plane, then replays the block once per bit plane, from that plane down to plane 0, in JPEG2000 stripe order: four coefficients per column, columns left to right, stripes top to bottom. It generalises the fixed 8x8, single-plane, free-running stimulus to any block size and coefficient width, multi-plane replay, partial stripes, and backpressure.

## Interface
- `CB_W`, default 8: code-block width in columns, 4..64.
- `CB_H`, default 8: code-block height in rows, 1..64; need not be a multiple of 4.
- `W_COEF`, default 16: coefficient width; bit `W_COEF-1` is the sign, bits `W_COEF-2:0` are the magnitude.
- `W_BP`, default `$clog2(W_COEF-1)`: width of `bit_pos`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input coefficient valid.
- `in_ready` out 1: block can accept a coefficient.
- `in_coeff` in `W_COEF`: raster-order sign-magnitude coefficient.
- `out_ready` in 1: downstream accepts the current beat.
- `coef_en` out 1: output beat valid.
- `coeff0`..`coeff3` out `W_COEF` each: stripe column, rows 4s+0..4s+3.
- `row_mask` out 4: bit k=1 when row 4s+k exists (partial last stripe).
- `first_row` out 1: beat belongs to stripe 0.
- `first_col` out 1: column 0 of a stripe.
- `last_col` out 1: column `CB_W-1` of a stripe.
- `first_plane` out 1: beat belongs to the top plane.
- `bit_pos` out `W_BP`: current plane index.
- `plane_end` out 1: last beat of a plane.
- `cb_done` out 1: one-cycle pulse when the block is finished.
- `cb_empty` out 1: one-cycle pulse when all magnitudes are zero.

## Operation
States are IDLE, LOAD, SCAN.

- **IDLE:** `in_ready`=1. The first accepted coefficient moves to LOAD with count=1. It clears the magnitude OR accumulator, then ORs this coefficient in.
- **LOAD:** `in_ready`=1. Each accepted coefficient (`in_valid & in_ready`) is written to bank (row mod 4), address (row/4)*CB_W + col. Its magnitude is ORed into the accumulator.
  - Row and column counters advance; the column wraps at `CB_W-1`.
  - After sample `CB_W*CB_H` is accepted, the block computes top = index of the highest set bit of the accumulator.
  - If the accumulator is 0, it pulses `cb_empty` and returns to IDLE; no output beats are produced.
  - Otherwise it enters SCAN with `bit_pos`=top.
- **SCAN:** `in_ready`=0. The block emits `ceil(CB_H/4)*CB_W` beats per plane.
  - Coefficients are passed unmodified, full sign-magnitude; `bpc` extracts the bit.
  - Rows with index ≥ `CB_H` output 0 with `row_mask` bit 0.
  - After the `plane_end` beat is accepted, `bit_pos` decrements.
  - After the plane-0 `plane_end` beat is accepted, `cb_done` pulses on the next cycle and the state returns to IDLE.
- **Flags** are valid only with `coef_en`:
  - `first_plane` is set when `bit_pos`==top.
  - `first_row` is set when stripe==0.
  - `first_col` and `last_col` are decoded from the column counter.
  - `plane_end` = last stripe AND `last_col`.
- **Reset:** all outputs are 0 (`in_ready` 0 during reset, 1 on the first cycle after deassert). State is IDLE, counters and accumulator are 0. Memory contents are don't-care. Reset asserted mid-LOAD or mid-SCAN aborts the block; no `cb_done` is produced.

## Timing
- **Input handshake:** standard valid/ready; at most one coefficient accepted per cycle.
- **Latency:** if the last input is accepted in cycle T, top is registered at T+1 and the first `coef_en` is at T+2.
- **Output handshake:**
  - A beat transfers when `coef_en & out_ready`.
  - While `coef_en`=1 and `out_ready`=0, every output holds stable.
  - `coef_en` never drops without a transfer.
- **Throughput:** with `out_ready` held high, beats are contiguous across stripe and plane boundaries; a block totals (top+1)*`ceil(CB_H/4)`*`CB_W` beats with zero bubbles.
- **Memory:** 1-cycle read latency, hidden by read-ahead. The read address advances only when the output register is empty or transferring.
- **Pulses:** `cb_done` and `cb_empty` last exactly one cycle. The new block's first input can be accepted in the same cycle as `cb_done` or `cb_empty`, since the state is already IDLE.
- **Simultaneous events:** a `plane_end` transfer and the `bit_pos` decrement take effect on the same edge.

## Test plan
- **Full 8x8 block:** 8x8, `W_COEF`=16; all magnitudes ≤ 0x7F and one equal to 0x7F. Required: top=6, 7 planes × 16 = 112 beats, `bit_pos` 6→0. `first_plane` is set only on beats 0–15, `cb_done` is set one cycle after beat 111, and sign bits are preserved.
- **Partial stripe:** `CB_H`=6, `CB_W`=4, magnitude max 1. Required: 1 plane of 8 beats. Stripe 1 has `row_mask`=4'b0011 with `coeff2` and `coeff3` equal to 0; `first_row` is set on beats 0–3 only.
- **All-zero block:** all 64 magnitudes are 0 (signs set). Required: `cb_empty` pulses at T+1, `coef_en` is never asserted, and the next block is accepted.
- **Backpressure:** random `out_ready` (50%) on the full 8x8 block. Required: an identical beat sequence to the `out_ready`=1 run, with outputs stable while stalled and no lost or duplicated beats.
- **Input gaps and back-to-back blocks:** `in_valid` toggling during LOAD, then a second block offered during SCAN. Required: `in_ready`=0 throughout SCAN, the second block is loaded only after `cb_done`, and its data is correct.
- **Reset mid-SCAN:** assert `rst` at plane 3 beat 5. Required: all outputs drop to 0 asynchronously, the state is IDLE, and a fresh block is then processed correctly.
